// File: rtl/blit_pkg.sv
// Shared constants and types for the blitter register decoder and its posted-write queue.
package blit_pkg;

   localparam int unsigned ADDR_W_DEF    = 6;
   localparam int unsigned NREG_DEF      = 1 << ADDR_W_DEF;
   localparam int unsigned LOCK_BASE_DEF = 16;
   localparam int unsigned QDEPTH_DEF    = 4;
   localparam int unsigned DATA_W_DEF    = 32;

   // Registers 1, 14, 27 and 30 have read side effects in the blitter.
   localparam logic [63:0] RD_MASK_DEF = 64'h0000_0000_4800_4002;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] idx;
      logic [DATA_W_DEF-1:0] data;
   } blit_wr_t;

endpackage

// File: rtl/blit_wrq.sv
// Synchronous FIFO holding deferred GPU writes to locked blitter registers.
module blit_wrq
   import blit_pkg::*;
#(
   parameter type         T     = blit_wr_t,
   parameter int unsigned DEPTH = QDEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     resetl,
   input  logic                     push,
   input  T                         din,
   input  logic                     pop,
   output T                         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);

   T               mem [DEPTH];
   logic [PW-1:0]  wp;
   logic [PW-1:0]  rp;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rp];

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/blit_regdec.sv
// GPU-to-blitter register decoder: registered load/read strobes, with writes to
// locked registers posted to a queue while a blit runs and replayed in order afterwards.
module blit_regdec
   import blit_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned LOCK_BASE = LOCK_BASE_DEF,
   parameter int unsigned QDEPTH    = QDEPTH_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter logic [(1<<ADDR_W)-1:0] RD_MASK = ((1<<ADDR_W))'(RD_MASK_DEF)
) (
   input  logic                      clk,
   input  logic                      resetl,
   input  logic                      bliten,
   input  logic                      gpu_memw,
   input  logic [ADDR_W+1:0]         gpu_addr,
   input  logic [DATA_W-1:0]         gpu_dout,
   input  logic                      blit_back,
   input  logic [(1<<ADDR_W)-1:0]    ext_ld,
   output logic                      gpu_ready,
   output logic [(1<<ADDR_W)-1:0]    ld_strobe,
   output logic [DATA_W-1:0]         ld_data,
   output logic [(1<<ADDR_W)-1:0]    rd_strobe,
   output logic [$clog2(QDEPTH):0]   q_count
);

   localparam int unsigned NREG = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LOCK_IDX = ADDR_W'(LOCK_BASE);

   typedef struct packed {
      logic [ADDR_W-1:0] idx;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic [ADDR_W-1:0]  idx;
   logic               locked;
   logic               wr;
   logic               direct;
   logic               push;
   logic               pop;
   logic               q_full;
   logic               q_empty;
   wr_t                q_din;
   wr_t                q_head;
   logic [NREG-1:0]    strb_q;
   logic               unused_addr;

   assign idx         = gpu_addr[ADDR_W+1:2];
   assign unused_addr = ^gpu_addr[1:0];
   assign locked      = (idx >= LOCK_IDX);

   assign gpu_ready = ~(q_full & bliten & gpu_memw & locked);
   assign wr        = bliten & gpu_memw & gpu_ready;

   // A non-empty queue keeps absorbing locked writes so they never overtake older ones.
   assign direct = wr & (~locked | (~blit_back & q_empty));
   assign push   = wr & locked & (blit_back | ~q_empty);
   assign pop    = ~blit_back & ~q_empty & ~direct;

   assign q_din.idx  = idx;
   assign q_din.data = gpu_dout;

   blit_wrq #(
      .T     (wr_t),
      .DEPTH (QDEPTH)
   ) u_wrq (
      .clk    (clk),
      .resetl (resetl),
      .push   (push),
      .din    (q_din),
      .pop    (pop),
      .dout   (q_head),
      .full   (q_full),
      .empty  (q_empty),
      .count  (q_count)
   );

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         strb_q    <= '0;
         ld_data   <= '0;
         rd_strobe <= '0;
      end else begin
         strb_q    <= '0;
         rd_strobe <= '0;
         if (direct) begin
            strb_q[idx] <= 1'b1;
            ld_data     <= gpu_dout;
         end else if (pop) begin
            strb_q[q_head.idx] <= 1'b1;
            ld_data            <= q_head.data;
         end
         if (bliten && !gpu_memw) rd_strobe[idx] <= RD_MASK[idx];
      end
   end

   assign ld_strobe = strb_q | ext_ld;

endmodule

// File: tb/tb_blit_regdec.sv
// Directed self-checking bench for blit_regdec with default parameters.
module tb_blit_regdec;

   logic        clk = 1'b0;
   logic        resetl;
   logic        bliten;
   logic        gpu_memw;
   logic [7:0]  gpu_addr;
   logic [31:0] gpu_dout;
   logic        blit_back;
   logic [63:0] ext_ld;
   logic        gpu_ready;
   logic [63:0] ld_strobe;
   logic [31:0] ld_data;
   logic [63:0] rd_strobe;
   logic [2:0]  q_count;

   int checks = 0;
   int errors = 0;

   blit_regdec dut (
      .clk       (clk),
      .resetl    (resetl),
      .bliten    (bliten),
      .gpu_memw  (gpu_memw),
      .gpu_addr  (gpu_addr),
      .gpu_dout  (gpu_dout),
      .blit_back (blit_back),
      .ext_ld    (ext_ld),
      .gpu_ready (gpu_ready),
      .ld_strobe (ld_strobe),
      .ld_data   (ld_data),
      .rd_strobe (rd_strobe),
      .q_count   (q_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input int unsigned i, input logic [31:0] d);
      bliten   = 1'b1;
      gpu_memw = 1'b1;
      gpu_addr = {i[5:0], 2'b00};
      gpu_dout = d;
   endtask

   task automatic set_rd(input int unsigned i);
      bliten   = 1'b1;
      gpu_memw = 1'b0;
      gpu_addr = {i[5:0], 2'b11};
      gpu_dout = '0;
   endtask

   task automatic set_idle();
      bliten   = 1'b0;
      gpu_memw = 1'b0;
      gpu_addr = '0;
      gpu_dout = '0;
   endtask

   initial begin
      resetl = 1'b0;
      for (int n = 0; n < 3; n++) begin
         bliten    = 1'($urandom);
         gpu_memw  = 1'($urandom);
         gpu_addr  = 8'($urandom);
         gpu_dout  = $urandom;
         blit_back = 1'($urandom);
         ext_ld    = {$urandom, $urandom};
         step();
      end
      chk("rst_ld", ld_strobe, ext_ld);
      chk("rst_rd", rd_strobe, 64'd0);
      chk("rst_qc", 64'(q_count), 64'd0);
      chk("rst_rdy", 64'(gpu_ready), 64'd1);
      chk("rst_data", 64'(ld_data), 64'd0);

      set_idle();
      blit_back = 1'b0;
      ext_ld    = '0;
      step();
      resetl = 1'b1;
      step();
      chk("idle_ld", ld_strobe, 64'd0);

      // direct write
      set_wr(3, 32'h1234_5678);
      step();
      set_idle();
      chk("dir_ld", ld_strobe, 64'h8);
      chk("dir_data", 64'(ld_data), 64'h1234_5678);
      step();
      chk("dir_once", ld_strobe, 64'd0);

      // deferred writes
      blit_back = 1'b1;
      set_wr(20, 32'hA); step(); chk("def_ld0", ld_strobe, 64'd0);
      set_wr(21, 32'hB); step(); chk("def_ld1", ld_strobe, 64'd0);
      set_wr(20, 32'hC); step(); chk("def_ld2", ld_strobe, 64'd0);
      set_idle();
      chk("def_qc3", 64'(q_count), 64'd3);
      blit_back = 1'b0;
      step();
      chk("def_s0", ld_strobe, 64'h1 << 20);
      chk("def_d0", 64'(ld_data), 64'hA);
      step();
      chk("def_s1", ld_strobe, 64'h1 << 21);
      chk("def_d1", 64'(ld_data), 64'hB);
      step();
      chk("def_s2", ld_strobe, 64'h1 << 20);
      chk("def_d2", 64'(ld_data), 64'hC);
      chk("def_qc0", 64'(q_count), 64'd0);
      step();
      chk("def_end", ld_strobe, 64'd0);

      // full stall
      blit_back = 1'b1;
      for (int unsigned k = 0; k < 4; k++) begin
         set_wr(16 + k, 32'(k + 1));
         step();
      end
      chk("full_qc4", 64'(q_count), 64'd4);
      set_wr(22, 32'h5);
      #1;
      chk("full_rdy0", 64'(gpu_ready), 64'd0);
      step();
      chk("full_hold", 64'(q_count), 64'd4);
      chk("full_nold", ld_strobe, 64'd0);
      blit_back = 1'b0;
      #1;
      chk("full_rdy0b", 64'(gpu_ready), 64'd0);
      step();
      chk("full_s16", ld_strobe, 64'h1 << 16);
      chk("full_d1", 64'(ld_data), 64'h1);
      chk("full_qc3", 64'(q_count), 64'd3);
      chk("full_rdy1", 64'(gpu_ready), 64'd1);
      step();
      set_idle();
      chk("full_s17", ld_strobe, 64'h1 << 17);
      chk("full_qc3b", 64'(q_count), 64'd3);
      step();
      chk("full_s18", ld_strobe, 64'h1 << 18);
      step();
      chk("full_s19", ld_strobe, 64'h1 << 19);
      chk("full_d4", 64'(ld_data), 64'h4);
      step();
      chk("full_s22", ld_strobe, 64'h1 << 22);
      chk("full_d5", 64'(ld_data), 64'h5);
      chk("full_qc0", 64'(q_count), 64'd0);

      // direct write has priority over drain; locked write during drain queues behind
      blit_back = 1'b1;
      set_wr(18, 32'h18);
      step();
      chk("pri_qc1", 64'(q_count), 64'd1);
      blit_back = 1'b0;
      set_wr(2, 32'h2);
      step();
      chk("pri_s2", ld_strobe, 64'h4);
      chk("pri_d2", 64'(ld_data), 64'h2);
      chk("pri_qc1b", 64'(q_count), 64'd1);
      set_wr(17, 32'h17);
      step();
      set_idle();
      chk("pri_s18", ld_strobe, 64'h1 << 18);
      chk("pri_d18", 64'(ld_data), 64'h18);
      chk("pri_qc1c", 64'(q_count), 64'd1);
      step();
      chk("pri_s17", ld_strobe, 64'h1 << 17);
      chk("pri_d17", 64'(ld_data), 64'h17);
      chk("pri_qc0", 64'(q_count), 64'd0);

      // reads and external loads
      set_rd(14);
      step();
      chk("rd14", rd_strobe, 64'h1 << 14);
      chk("rd14_ld", ld_strobe, 64'd0);
      set_rd(15);
      step();
      chk("rd15", rd_strobe, 64'd0);
      set_rd(30);
      step();
      set_idle();
      chk("rd30", rd_strobe, 64'h1 << 30);
      chk("rd_qc", 64'(q_count), 64'd0);
      step();
      chk("rd_off", rd_strobe, 64'd0);
      ext_ld = 64'h1 << 5;
      #1;
      chk("ext5", ld_strobe, 64'h20);
      ext_ld = '0;

      // reset mid-operation drops queued writes
      blit_back = 1'b1;
      set_wr(25, 32'h25); step();
      set_wr(26, 32'h26); step();
      set_idle();
      chk("mr_qc2", 64'(q_count), 64'd2);
      resetl = 1'b0;
      #1;
      chk("mr_qc0", 64'(q_count), 64'd0);
      step();
      resetl    = 1'b1;
      blit_back = 1'b0;
      step();
      step();
      chk("mr_noload", ld_strobe, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/blit_regdec.md
Name: blit_regdec

Overview:
- Parametrised, registered successor to the GPU-to-blitter register write/read decoder in TOM.
- Decodes GPU word addresses into one-hot load strobes for NREG blitter registers, and ORs in blitter-internal load requests.
- Adds a posted-write queue: GPU writes to registers that are locked while a blit is running are deferred, then replayed in order after the blit completes.
- Sits between the GPU local bus and the blitter register file.

Parameters:
- ADDR_W, 6, word-address bits decoded (gpu_addr[ADDR_W+1:2]); NREG = 2**ADDR_W.
- LOCK_BASE, 16, first locked register index; indices >= LOCK_BASE are locked while blit_back=1.
- QDEPTH, 4, posted-write queue depth (power of 2, >= 2).
- DATA_W, 32, write data width.
- RD_MASK, NREG-bit constant, default bits {1,14,27,30} set: registers with a read strobe.

Ports:
- clk  in  1  system clock
- resetl  in  1  asynchronous active-low reset
- bliten  in  1  blitter chip-select for the current GPU cycle
- gpu_memw  in  1  1 = write, 0 = read
- gpu_addr  in  ADDR_W+2  byte address; bits [1:0] ignored
- gpu_dout  in  DATA_W  GPU write data
- blit_back  in  1  blit active; locks registers >= LOCK_BASE
- ext_ld  in  NREG  blitter-internal load requests, ORed into ld_strobe
- gpu_ready  out  1  0 = stall the GPU write (queue full)
- ld_strobe  out  NREG  one-hot registered load strobe | ext_ld
- ld_data  out  DATA_W  data accompanying ld_strobe
- rd_strobe  out  NREG  registered read strobes (masked by RD_MASK)
- q_count  out  $clog2(QDEPTH)+1  queue occupancy (debug/status)

Behaviour:
- Reset values: all registered ld_strobe bits 0, ld_data 0, rd_strobe 0, queue empty, q_count 0. gpu_ready is combinational and equals 1 in reset.
- A write is accepted when wr = bliten & gpu_memw & gpu_ready. Let idx = gpu_addr[ADDR_W+1:2] and locked = idx >= LOCK_BASE.
- Direct path applies when wr & (!locked | (!blit_back & queue empty)).
  - Next cycle: ld_strobe[idx]=1 and ld_data=gpu_dout. Latency is 1 clock.
- Enqueue path applies when wr & locked & (blit_back | queue non-empty).
  - The {idx, gpu_dout} pair is pushed.
  - A queue non-empty condition forces enqueueing even after blit_back falls, to preserve write order to locked registers.
- Drain: when blit_back=0 and the queue is non-empty and no direct-path issue occurs this cycle, pop the head. Next cycle that register's strobe and data are output.
  - Direct unlocked writes have priority over drain, because there is a single data bus.
- gpu_ready = !(queue full & bliten & gpu_memw & locked).
  - Push and pop in the same cycle on a full queue does not occur, since a full queue blocks the push. Pop while a push occurs on a non-full queue is legal, with count unchanged.
- Registered strobe is at most one bit per cycle. The final ld_strobe = registered strobe | ext_ld. ext_ld is not registered and carries no data.
- Read: when bliten & !gpu_memw, next cycle rd_strobe[idx] = RD_MASK[idx]; otherwise 0. Reads never stall or enqueue.
- blit_back rising mid-drain stops the drain after the current pop. The remaining entries wait.
- Async reset mid-operation discards queued writes silently.
- Pointers wrap modulo QDEPTH. q_count ranges 0..QDEPTH.

Decomposition:
- Shared package blit_pkg holds:
  - NREG/ADDR_W-derived constants
  - LOCK_BASE default
  - typedef blit_wr_t {idx, data}
  - RD_MASK default constant
- One sub-module: blit_wrq, a synchronous FIFO of blit_wr_t.
  - Ports: push, pop, full, empty, count.
  - Asynchronous active-low reset.

Test Plan:
- Reset: hold resetl=0 with random inputs -> ld_strobe=ext_ld, rd_strobe=0, q_count=0, gpu_ready=1.
- Direct write: blit_back=0, write idx 3 data 0x12345678 -> next cycle ld_strobe=1<<3, ld_data=0x12345678 for exactly 1 cycle.
- Deferred writes: blit_back=1, write idx 20=0xA, 21=0xB, 20=0xC -> no strobes, q_count=3. Drop blit_back -> strobes 20/0xA, 21/0xB, 20/0xC on 3 consecutive cycles, then q_count=0.
- Full stall: blit_back=1, 5 locked writes with QDEPTH=4 -> gpu_ready=0 on the 5th write. It is accepted 1 cycle after the first pop once blit_back=0, and its strobe follows the 4th in order.
- Priority: queue holds idx 18, blit_back=0, simultaneous unlocked write idx 2 -> idx 2 strobes first, idx 18 strobes the following cycle. A locked write to idx 17 in the drain cycle enqueues behind 18.
- Read/ext: read idx 14 -> rd_strobe[14]=1 next cycle. Read idx 15 -> rd_strobe=0. ext_ld[5]=1 -> ld_strobe[5]=1 in the same cycle.
